// File: rtl/pipelined_carry_adder_pkg.sv
// Purpose: shared constants and elaboration helpers for the pipelined carry adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   chunk_width()  - bits summed per pipeline stage (WIDTH / STAGES)
//   chunk_cfg_ok() - legality of a WIDTH/STAGES pairing, checked at elaboration
// Optional feature macro seen by users of this package: ADDER_SUB_EN.
package adder_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    // Width of the ripple chunk handled by one stage. A zero stage count is
    // rejected by chunk_cfg_ok; returning the full width keeps the arithmetic
    // well defined until that check fires.
    function automatic int chunk_width(input int width, input int stages);
        if (stages < 1) begin
            return width;
        end
        return width / stages;
    endfunction

    // The datapath splits evenly into STAGES chunks of at least one bit.
    function automatic bit chunk_cfg_ok(input int width, input int stages);
        if (stages < 1) begin
            return 1'b0;
        end
        if (width < stages) begin
            return 1'b0;
        end
        return (width % stages) == 0;
    endfunction

endpackage

// File: rtl/pipelined_carry_adder_if.sv
// Purpose: operand/result handshake bundle for the pipelined carry adder.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
//
// Signals: in_valid, in_ready, a, b, cin, out_valid, out_ready, s, cout.
// With ADDER_SUB_EN defined the bundle also carries sub (operand side) and
// ovf (result side).
// Modports: master = producer/consumer around the adder, slave = the adder.
interface pipelined_carry_adder_if #(
    parameter int WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;

`ifdef ADDER_SUB_EN
    logic             sub;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, s, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, s, cout
    );
`endif

endinterface

// File: rtl/pipelined_carry_adder_chunk_stage.sv
// Purpose: one pipeline stage - CHUNK-bit ripple adder on chunk IDX plus its register slice.
// Latency: 1 cycle (result registered on the rising edge when en_i=1).
// Backpressure: en_i=0 holds every register of the slice, valid bit included.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   en_i              global advance; load the slice when high
//   vld_i / vld_o     slot valid in / registered out
//   a_i, b_i          full-width operand skew buffers in; a_o, b_o registered copies
//   sum_i / sum_o     partial sum with chunks 0..IDX-1 filled / chunks 0..IDX filled
//   c_i / c_o         carry into this chunk / registered carry out of this chunk
module adder_chunk_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             c_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_o
);

    localparam int LSB = IDX * CHUNK;
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}}) << LSB;

    logic [CHUNK-1:0] chunk_sum;
    logic             carry_d;
    logic [WIDTH-1:0] sum_d;

    logic             vld_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    // Chained full adders across the chunk. carry_d walks up the chain and
    // leaves the loop as the carry out of the top bit of the chunk.
    always_comb begin
        carry_d   = c_i;
        chunk_sum = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_sum[i] = a_i[LSB+i] ^ b_i[LSB+i] ^ carry_d;
            carry_d      = (a_i[LSB+i] & b_i[LSB+i])
                         | (carry_d & (a_i[LSB+i] ^ b_i[LSB+i]));
        end
    end

    // Drop this chunk into the partial sum; lower chunks pass through untouched.
    always_comb begin
        sum_d = (sum_i & ~CHUNK_MASK) | (WIDTH'(chunk_sum) << LSB);
    end

    // The whole operand pair moves with the slot so later stages see their
    // chunks; bits already consumed have no load downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else if (en_i) begin
            vld_q   <= vld_i;
            a_q     <= a_i;
            b_q     <= b_i;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign vld_o = vld_q;
    assign a_o   = a_q;
    assign b_o   = b_q;
    assign sum_o = sum_q;
    assign c_o   = carry_q;

endmodule

// File: rtl/pipelined_carry_adder.sv
// Purpose: WIDTH-bit adder split into STAGES registered ripple chunks, one operand pair per cycle.
// Latency: exactly STAGES cycles from input transfer to out_valid when not stalled.
// Backpressure: whole pipe advances only when the output slot is empty or taken; in_ready follows.
//
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   io (slave)  in_valid/in_ready, a, b, cin  -> operand side
//               out_valid/out_ready, s, cout  -> result side
// Optional feature ADDER_SUB_EN: adds io.sub (a + ~b + 1, cin ignored,
// cout=1 means no borrow) and io.ovf (signed overflow of the final result).
module pipelined_carry_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    pipelined_carry_adder_if.slave       io
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    generate
        if (!chunk_cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
            $error("pipelined_carry_adder: WIDTH must be a non-zero multiple of STAGES (STAGES >= 1)");
        end
    endgenerate

    // Index 0 is the entry point fed from the ports; index k+1 is the
    // register slice of stage k; index STAGES drives the outputs.
    logic [STAGES:0]            vld_pipe;
    logic [STAGES:0]            c_pipe;
    logic [STAGES:0][WIDTH-1:0] a_pipe;
    logic [STAGES:0][WIDTH-1:0] b_pipe;
    logic [STAGES:0][WIDTH-1:0] sum_pipe;

    logic             adv;
    logic [WIDTH-1:0] b_entry;
    logic             c_entry;

`ifdef ADDER_SUB_EN
    // Subtraction is folded in once at entry: the inverted B travels down the
    // pipe, which is also the B whose sign bit the overflow test needs.
    assign b_entry = io.sub ? ~io.b : io.b;
    assign c_entry = io.sub ? 1'b1  : io.cin;
`else
    assign b_entry = io.b;
    assign c_entry = io.cin;
`endif

    assign vld_pipe[0] = io.in_valid;
    assign a_pipe[0]   = io.a;
    assign b_pipe[0]   = b_entry;
    assign sum_pipe[0] = '0;
    assign c_pipe[0]   = c_entry;

    // Single global enable: the pipe never compresses bubbles, so a stall
    // anywhere freezes everything and no slot is lost or duplicated.
    assign adv         = !vld_pipe[STAGES] || io.out_ready;
    assign io.in_ready = rst_n && adv;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            adder_chunk_stage #(
                .WIDTH (WIDTH),
                .CHUNK (CHUNK),
                .IDX   (k)
            ) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .en_i  (adv),
                .vld_i (vld_pipe[k]),
                .a_i   (a_pipe[k]),
                .b_i   (b_pipe[k]),
                .sum_i (sum_pipe[k]),
                .c_i   (c_pipe[k]),
                .vld_o (vld_pipe[k+1]),
                .a_o   (a_pipe[k+1]),
                .b_o   (b_pipe[k+1]),
                .sum_o (sum_pipe[k+1]),
                .c_o   (c_pipe[k+1])
            );
        end
    endgenerate

    assign io.out_valid = vld_pipe[STAGES];
    assign io.s         = sum_pipe[STAGES];
    assign io.cout      = c_pipe[STAGES];

`ifdef ADDER_SUB_EN
    // Operands of equal sign producing a result of the other sign. All three
    // inputs come from reset-cleared registers, so ovf is 0 out of reset.
    assign io.ovf = (a_pipe[STAGES][WIDTH-1] == b_pipe[STAGES][WIDTH-1])
                 && (sum_pipe[STAGES][WIDTH-1] != a_pipe[STAGES][WIDTH-1]);
`endif

    // Operand copies leaving the last stage have no consumer.
    logic unused_operands;
    assign unused_operands = ^{a_pipe[STAGES], b_pipe[STAGES]};

endmodule

// File: doc/pipelined_carry_adder.md
Name: pipelined_carry_adder

Overview:
- Parametrised, pipelined successor to the team's 4-bit ripple-carry adder for the processor datapath.
- Splits a WIDTH-bit add into STAGES equal chunks. Each chunk is a ripple adder, and the carry between chunks is registered.
- Accepts one operand pair per cycle under a valid/ready handshake, with full backpressure.
- Feeds the ALU result path where a single-cycle WIDTH-bit ripple add cannot meet timing.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; chunk width CHUNK = WIDTH/STAGES; STAGES >= 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- s  output  WIDTH  sum a+b+cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset (asynchronous, rst_n=0): all stage valid bits clear, so out_valid=0, s=0, cout=0. Any in-flight operations are discarded, with no partial output.
- in_ready is 0 while rst_n=0.
- Global advance: adv = !out_valid || out_ready. in_ready = adv, combinational.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Stage k (0..STAGES-1) computes chunk k: bits [k*CHUNK +: CHUNK] of a and b, plus the carry registered from stage k-1. Stage 0 uses cin.
- Each stage forwards to the next register:
  - the already-computed lower sum bits;
  - the not-yet-summed upper a/b chunks (skew buffering);
  - its own carry out;
  - its valid bit.
- When adv=0, every stage register holds, including valid bits. No bubble is inserted and no data is lost.
- When adv=1, every stage shifts. Stage 0 captures {a, b, cin} with valid = in_valid.
- Latency: exactly STAGES cycles from the input transfer to out_valid=1 when there is no stall. Throughput: 1 result per cycle.
- Bubbles propagate as invalid slots. s and cout are unspecified while out_valid=0, but must not contain X after reset.
- Carry boundary: a carry generated in chunk k is consumed by chunk k+1 one cycle later. The result must equal the full-width sum for all inputs, including all-ones + 1.
- STAGES=1 degenerates to a registered single ripple adder with latency 1.
- Simultaneous input and output transfer in the same cycle is legal and keeps the pipeline full.
- Reset asserted mid-stream: outputs drop to 0 and out_valid to 0 immediately (asynchronously). No result is produced after release until new operands are accepted.

Optional Feature:
- Macro ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands and carried in the pipeline.
  - When sub=1, the block computes a + ~b + 1 and cin is ignored. cout=1 means no borrow.
  - When sub=0, the block adds as normal.
  - Adds output port ovf (1 bit, reset 0): signed overflow of the final result, (a[MSB]==b_eff[MSB]) && (s[MSB]!=a[MSB]), valid with out_valid.
- Undefined: no sub or ovf ports; add only.

Decomposition:
- Shared package adder_pkg holds:
  - the CHUNK width derivation (WIDTH/STAGES) as a constant function;
  - a WIDTH % STAGES == 0 elaboration check.
- One natural sub-module: adder_chunk_stage. It is the combinational CHUNK-bit ripple adder (chained full adders) plus that stage's pipeline register slice with the hold-on-stall enable. It is instantiated STAGES times in a generate loop.

Test Plan (WIDTH=16, STAGES=4 unless noted):
- Basic add: a=0x0005, b=0x000F, cin=0 -> exactly 4 cycles later out_valid=1, s=0x0014, cout=0.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1. Also a=0xFFFF, b=0x0000, cin=1 -> s=0x0000, cout=1.
- Streaming: 8 back-to-back pairs with out_ready=1 -> 8 consecutive valid results in order, one per cycle, each matching the reference a+b+cin.
- Backpressure: out_ready=0 for 5 cycles while the pipe is full -> in_ready=0, s and cout held stable. On release, all results emerge in order with none lost or duplicated.
- Reset mid-operation: assert rst_n=0 with 3 operations in flight -> out_valid=0 and s=0 immediately. After release with no new input, out_valid stays 0.
- ADDER_SUB_EN: sub=1, a=0x0003, b=0x0005 -> s=0xFFFE, cout=0, ovf=0. Also sub=1, a=0x8000, b=0x0001 -> s=0x7FFF, ovf=1.
